// File: rtl/popcnt_pkg.sv
// Shared types and constants for the popcount group accumulator.
package popcnt_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/popcnt_sat_add.sv
// Saturating adder: acc + zero-extended cnt, clamped at all-ones.
// Purely combinational; no latency, no flow control.
import popcnt_pkg::*;

module popcnt_sat_add #(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [CNT_W-1:0] cnt,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    logic [ACC_W:0] wide;

    // One carry bit is enough: cnt never exceeds 15 and ACC_W is at least 5.
    assign wide = {1'b0, acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, cnt};
    assign sat  = wide[ACC_W];
    assign sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/popcnt_accum.sv
// Accumulates per-beat popcounts into a group total with sticky saturation.
// Result valid 1 cycle after the in_last transfer; in_ready low while a result is held.
// Optional POPCNT_THRESH_EN adds a threshold compare (thresh / out_act).
import popcnt_pkg::*;

module popcnt_accum #(
    parameter int ACC_W  = 12,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [BEAT_W-1:0] out_beats,
    output logic              out_sat
`ifdef POPCNT_THRESH_EN
    ,
    input  logic [ACC_W-1:0]  thresh,
    output logic              out_act
`endif
);

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [ACC_W-1:0]  add_sum;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [BEAT_W-1:0] obeats_q, obeats_d;
    logic [BEAT_W-1:0] beats_inc;
    logic              sticky_q, sticky_d;
    logic              osat_q, osat_d;
    logic              rdy_en_q;
    logic              add_sat;
    logic              illegal;
    logic              beat_ovf;
    logic              flag;
    logic              in_xfer;
    logic              out_xfer;
`ifdef POPCNT_THRESH_EN
    logic              act_q, act_d;
`endif

    popcnt_sat_add #(.ACC_W(ACC_W)) u_add (
        .acc (acc_q),
        .cnt (in_cnt),
        .sum (add_sum),
        .sat (add_sat)
    );

    assign illegal   = in_cnt > MAX_CNT;
    assign beat_ovf  = &beats_q;
    assign beats_inc = beat_ovf ? beats_q : beats_q + BEAT_W'(1);
    assign flag      = sticky_q | add_sat | illegal | beat_ovf;

    // rdy_en_q keeps in_ready low through reset and rises on the first edge after it.
    assign in_ready  = rdy_en_q && (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign out_sum   = sum_q;
    assign out_beats = obeats_q;
    assign out_sat   = osat_q;
`ifdef POPCNT_THRESH_EN
    assign out_act   = act_q;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        beats_d  = beats_q;
        sticky_d = sticky_q;
        sum_d    = sum_q;
        obeats_d = obeats_q;
        osat_d   = osat_q;
`ifdef POPCNT_THRESH_EN
        act_d    = act_q;
`endif
        case (state_q)
            IDLE, ACC: begin
                if (in_xfer) begin
                    if (in_last) begin
                        sum_d    = add_sum;
                        obeats_d = beats_inc;
                        osat_d   = flag;
`ifdef POPCNT_THRESH_EN
                        act_d    = add_sum >= thresh;
`endif
                        state_d  = HOLD;
                    end else begin
                        acc_d    = add_sum;
                        beats_d  = beats_inc;
                        sticky_d = flag;
                        state_d  = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    acc_d    = '0;
                    beats_d  = '0;
                    sticky_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            beats_q  <= '0;
            sticky_q <= 1'b0;
            sum_q    <= '0;
            obeats_q <= '0;
            osat_q   <= 1'b0;
            rdy_en_q <= 1'b0;
`ifdef POPCNT_THRESH_EN
            act_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            beats_q  <= beats_d;
            sticky_q <= sticky_d;
            sum_q    <= sum_d;
            obeats_q <= obeats_d;
            osat_q   <= osat_d;
            rdy_en_q <= 1'b1;
`ifdef POPCNT_THRESH_EN
            act_q    <= act_d;
`endif
        end
    end

endmodule

// File: tb/tb_popcnt_accum.sv
// Bench for popcnt_accum: a default instance (12/8) and a narrow one (ACC_W=5, BEAT_W=3).
module tb_popcnt_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] in_cnt = 4'd0;

    logic        rdy_a, vld_a, sat_a;
    logic [11:0] sum_a;
    logic [7:0]  beats_a;
    logic        rdy_b, vld_b, sat_b;
    logic [4:0]  sum_b;
    logic [2:0]  beats_b;
`ifdef POPCNT_THRESH_EN
    logic [11:0] thresh_a = 12'd0;
    logic [4:0]  thresh_b = 5'd0;
    logic        act_a, act_b;
`endif

    logic [31:0] c_rdy, c_vld, c_sum, c_beats, c_sat;
    assign c_rdy   = sel ? {31'b0, rdy_b}   : {31'b0, rdy_a};
    assign c_vld   = sel ? {31'b0, vld_b}   : {31'b0, vld_a};
    assign c_sum   = sel ? {27'b0, sum_b}   : {20'b0, sum_a};
    assign c_beats = sel ? {29'b0, beats_b} : {24'b0, beats_a};
    assign c_sat   = sel ? {31'b0, sat_b}   : {31'b0, sat_a};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    popcnt_accum u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (rdy_a),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .out_valid (vld_a),
        .out_ready (out_ready & ~sel),
        .out_sum   (sum_a),
        .out_beats (beats_a),
        .out_sat   (sat_a)
`ifdef POPCNT_THRESH_EN
        ,
        .thresh    (thresh_a),
        .out_act   (act_a)
`endif
    );

    popcnt_accum #(.ACC_W(5), .BEAT_W(3)) u_d5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (rdy_b),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .out_valid (vld_b),
        .out_ready (out_ready & sel),
        .out_sum   (sum_b),
        .out_beats (beats_b),
        .out_sat   (sat_b)
`ifdef POPCNT_THRESH_EN
        ,
        .thresh    (thresh_b),
        .out_act   (act_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted; returns one step after the transfer edge.
    task automatic beat(input logic s, input logic [3:0] c, input logic l);
        int n;
        n = 0;
        sel = s;
        in_cnt = c;
        in_last = l;
        in_valid = 1'b1;
        while (c_rdy !== 32'd1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("beat_accept_timeout", c_rdy, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_out(input string tag, input int es, input int eb, input int esat);
        chk({tag, "_vld"},   c_vld,   32'd1);
        chk({tag, "_sum"},   c_sum,   es);
        chk({tag, "_beats"}, c_beats, eb);
        chk({tag, "_sat"},   c_sat,   esat);
    endtask

    task automatic release_out(input string tag, input int hold, input int es, input int eb, input int esat);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_rdy"}, c_rdy, 32'd0);
            check_out({tag, "_hold"}, es, eb, esat);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_vld"}, c_vld, 32'd0);
        chk({tag, "_post_rdy"}, c_rdy, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       s;
        logic       bad;
        logic [3:0] c;
        int         n, total, maxs, maxb, es, eb, esat;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy_a", {31'b0, rdy_a}, 32'd0);
        chk("rst_rdy_b", {31'b0, rdy_b}, 32'd0);
        chk("rst_vld",   c_vld,   32'd0);
        chk("rst_sum",   c_sum,   32'd0);
        chk("rst_beats", c_beats, 32'd0);
        chk("rst_sat",   c_sat,   32'd0);
        rst = 1'b0;
        chk("rst_rdy_low_before_edge", c_rdy, 32'd0);
        tick();
        chk("rdy_after_rst", c_rdy, 32'd1);

        // 3,7,10 with last on 10
        beat(1'b0, 4'd3, 1'b0);
        chk("g1_vld_mid", c_vld, 32'd0);
        beat(1'b0, 4'd7, 1'b0);
        beat(1'b0, 4'd10, 1'b1);
        check_out("g1", 20, 3, 0);
        release_out("g1", 1, 20, 3, 0);

        // one-beat group from IDLE
        beat(1'b0, 4'd5, 1'b1);
        check_out("g2", 5, 1, 0);
        release_out("g2", 0, 5, 1, 0);

        // narrow accumulator saturates, next group is clean
        for (int i = 0; i < 4; i++) beat(1'b1, 4'd10, i == 3);
        check_out("g3", 31, 4, 1);
        release_out("g3", 0, 31, 4, 1);
        beat(1'b1, 4'd1, 1'b0);
        beat(1'b1, 4'd1, 1'b1);
        check_out("g4", 2, 2, 0);
        release_out("g4", 0, 2, 2, 0);

        // long backpressure on the result
        beat(1'b0, 4'd9, 1'b0);
        beat(1'b0, 4'd2, 1'b1);
        release_out("g5", 5, 11, 2, 0);

        // reset mid-group drops the partial sum
        beat(1'b0, 4'd6, 1'b0);
        beat(1'b0, 4'd9, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_rdy", c_rdy, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_rdy_after", c_rdy, 32'd1);
        beat(1'b0, 4'd4, 1'b0);
        beat(1'b0, 4'd4, 1'b1);
        check_out("g6", 8, 2, 0);
        release_out("g6", 0, 8, 2, 0);

        // illegal count is taken as given and flagged
        beat(1'b0, 4'd12, 1'b0);
        beat(1'b0, 4'd3, 1'b1);
        check_out("g7", 15, 2, 1);
        release_out("g7", 0, 15, 2, 1);

        // exactly 7 beats fits a 3-bit counter; 9 beats saturates it
        for (int i = 0; i < 7; i++) beat(1'b1, 4'd0, i == 6);
        check_out("g8", 0, 7, 0);
        release_out("g8", 0, 0, 7, 0);
        for (int i = 0; i < 9; i++) beat(1'b1, 4'd1, i == 8);
        check_out("g9", 9, 7, 1);
        release_out("g9", 0, 9, 7, 1);

`ifdef POPCNT_THRESH_EN
        thresh_a = 12'd15;
        beat(1'b0, 4'd10, 1'b0);
        beat(1'b0, 4'd6, 1'b1);
        check_out("th1", 16, 2, 0);
        chk("th1_act", {31'b0, act_a}, 32'd1);
        release_out("th1", 0, 16, 2, 0);
        thresh_a = 12'd17;
        beat(1'b0, 4'd10, 1'b0);
        beat(1'b0, 4'd6, 1'b1);
        chk("th2_act", {31'b0, act_a}, 32'd0);
        release_out("th2", 0, 16, 2, 0);
`endif

        // randomized groups against an arithmetic model
        for (int g = 0; g < 40; g++) begin
            s = g[0];
            n = s ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 12));
            maxs = s ? 31 : 4095;
            maxb = s ? 7 : 255;
            total = 0;
            bad = 1'b0;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(11, 15));
                else c = 4'($urandom_range(0, 10));
                repeat ($urandom_range(0, 2)) tick();
                beat(s, c, k == n - 1);
                total += int'(c);
                if (c > 4'd10) bad = 1'b1;
            end
            es   = (total > maxs) ? maxs : total;
            eb   = (n > maxb) ? maxb : n;
            esat = (total > maxs || bad || n > maxb) ? 1 : 0;
            check_out("rnd", es, eb, esat);
            release_out("rnd", int'($urandom_range(0, 3)), es, eb, esat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
